bit_serial_adder: RTL and testbench

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

---
 rtl/serial_arith_pkg.sv | 18 +
 rtl/fullAdder.sv | 19 +
 rtl/bit_serial_adder.sv | 112 +++++++++++
 tb/tb_bit_serial_adder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the serial arithmetic blocks.
// Holds the FSM state encoding, the flag bit positions and the default width.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int DEFAULT_WIDTH = 64;

endpackage

// File: rtl/fullAdder.sv
// Gate-level 1-bit full adder.
// This is the only adding element in the serial datapath.
module fullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic axb, g, p;

    xor u_x0 (axb, a, b);
    xor u_x1 (sum, axb, cin);
    and u_a0 (g, a, b);
    and u_a1 (p, axb, cin);
    or  u_o0 (cout, g, p);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial add/subtract: one bit pair per clock, LSB first, through a single full adder.
// Result and ARM64-style NZCV flags are held in DONE until the consumer takes them.
module bit_serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic             in_ready_q, out_valid_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic             carry_q;
    logic [CNT_W-1:0] count_q;
    logic [3:0]       flags_q;

    logic             fa_sum, fa_cout;
    logic [WIDTH-1:0] res_d;
    logic [3:0]       flags_d;

    fullAdder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Flags are formed from the result as it will look after the final shift.
    // carry_q is the carry into the MSB when the last bit pair is processed.
    always_comb begin
        res_d           = {fa_sum, result_q[WIDTH-1:1]};
        flags_d         = '0;
        flags_d[FLAG_N] = res_d[WIDTH-1];
        flags_d[FLAG_Z] = (res_d == '0);
        flags_d[FLAG_C] = fa_cout;
        flags_d[FLAG_V] = carry_q ^ fa_cout;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            count_q     <= '0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= A;
                        b_q        <= B ^ {WIDTH{sub}};
                        carry_q    <= sub;
                        count_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    carry_q  <= fa_cout;
                    result_q <= res_d;
                    if (count_q == LAST) begin
                        flags_q     <= flags_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    // No accept on the exit edge: in_ready only rises here.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder at WIDTH=8: directed cases, stall,
// mid-run operand noise, mid-run reset, and random ops against an arithmetic model.
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A, B;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain-arithmetic reference: returns {result, N, Z, C, V}.
    function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [7:0] bb;
        logic [8:0] full;
        logic [7:0] r;
        logic       v;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {8'd0, s};
        r    = full[7:0];
        v    = (a[7] == bb[7]) && (r[7] != a[7]);
        return {r, r[7], (r == 8'd0), full[8], v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE; optionally inject operand noise mid-run and stall in DONE.
    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input int hold, input bit noise);
        logic [11:0] exp;
        logic [7:0]  r0;
        logic [3:0]  f0;
        int          lat;
        bit          busy_ok;
        exp = model(a, b, s);
        A = a; B = b; sub = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 20) begin
            if (noise) begin
                in_valid = 1'b1;
                A = W'($urandom); B = W'($urandom); sub = 1'($urandom);
            end
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, 8);
        check("run_in_ready_low", busy_ok, 1);
        check("result", result, exp[11:4]);
        check("flags", flags, exp[3:0]);
        r0 = result; f0 = flags;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("stall_hold", {out_valid, in_ready, flags, result}, {1'b1, 1'b0, f0, r0});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("exit_idle", {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rs;
        bit         quiet;
        reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; sub = 1'b0; out_ready = 1'b0;
        #12;
        check("reset_outputs", {in_ready, out_valid, flags, result}, {1'b1, 1'b0, 4'h0, 8'h00});
        tick();
        reset = 1'b0;

        // First edge after reset release accepts.
        op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
        check("flags_7f_01", flags, 4'b1001);
        op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        check("flags_ff_01", flags, 4'b0110);
        op(8'h05, 8'h05, 1'b1, 0, 1'b0);
        check("flags_05m05", flags, 4'b0110);
        op(8'h03, 8'h05, 1'b1, 0, 1'b0);
        check("res_03m05", result, 8'hFE);
        op(8'h40, 8'h40, 1'b0, 5, 1'b0);
        op(8'h12, 8'h34, 1'b0, 0, 1'b1);
        check("noise_result", result, 8'h46);

        // Reset three RUN edges into an op.
        A = 8'h55; B = 8'h22; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        check("midrun_reset", {in_ready, out_valid, flags, result}, {1'b1, 1'b0, 4'h0, 8'h00});
        tick();
        reset = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
        end
        check("no_spurious_valid", quiet, 1);

        // Reset in DONE abandons the result.
        A = 8'h01; B = 8'h01; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("done_reached", out_valid, 1'b1);
        reset = 1'b1;
        #1;
        check("done_reset", {in_ready, out_valid, flags, result}, {1'b1, 1'b0, 4'h0, 8'h00});
        tick();
        reset = 1'b0;
        op(8'h80, 8'h80, 1'b0, 0, 1'b0);
        check("flags_80_80", flags, 4'b0111);

        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            if (n % 50 == 0) rb = ra;
            op(ra, rb, rs, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
